// File: rtl/msq_pkg.sv
// Shared definitions for the micro-sequencer write arbiter: FSM states,
// requester-count bounds, counter widths and flattened-bus slice helpers.
package msq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_FINISH     = 3'd4
  } arb_state_e;

  localparam int MIN_REQ    = 2;
  localparam int MAX_REQ    = 8;
  localparam int FAIL_CNT_W = 16;
  localparam int STRB_W     = 4;

  function automatic bit req_count_ok(input int n);
    return (n >= MIN_REQ) && (n <= MAX_REQ);
  endfunction

  // Low bit of requester idx inside a flattened vector of width-bit fields.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/msq_write_arbiter_if.sv
// Requester-side and write-master-side signals of the write arbiter.
// The arbiter uses the slave modport; the surrounding environment uses master.
interface msq_write_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  import msq_pkg::*;

  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_waddr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*STRB_W-1:0]     req_wstrb;
  logic [NUM_REQ-1:0]            req_grant;
  logic [NUM_REQ-1:0]            req_done;
  logic [NUM_REQ-1:0]            req_error;
  logic [ADDR_WIDTH-1:0]         m_axi_waddr;
  logic [DATA_WIDTH-1:0]         m_axi_wdata;
  logic [STRB_W-1:0]             m_axi_wstrb;
  logic                          m_axi_write;
  logic                          m_axi_write_busy;
  logic                          m_axi_write_failed;
  logic                          arb_busy;
  logic [FAIL_CNT_W-1:0]         fail_count;

  modport slave (
    input  req_write, req_waddr, req_wdata, req_wstrb,
    input  m_axi_write_busy, m_axi_write_failed,
    output req_grant, req_done, req_error,
    output m_axi_waddr, m_axi_wdata, m_axi_wstrb, m_axi_write,
    output arb_busy, fail_count
  );

  modport master (
    output req_write, req_waddr, req_wdata, req_wstrb,
    output m_axi_write_busy, m_axi_write_failed,
    input  req_grant, req_done, req_error,
    input  m_axi_waddr, m_axi_wdata, m_axi_wstrb, m_axi_write,
    input  arb_busy, fail_count
  );

endinterface

// File: rtl/msq_rr_picker.sv
// Round-robin request picker: first asserted request at or after rr_ptr,
// with rr_ptr advanced past the owner when a transaction finishes.
module msq_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv_en,
  input  logic [IDX_W-1:0]   adv_idx,
  output logic               pick_valid,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [IDX_W-1:0]   pick_idx
);

  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;
  logic [IDX_W-1:0] cand;
  logic             hit;

  always_comb begin
    pick_valid  = 1'b0;
    pick_onehot = '0;
    pick_idx    = '0;
    cand        = '0;
    hit         = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand              = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      hit               = !pick_valid && req[cand];
      pick_onehot[cand] = pick_onehot[cand] | hit;
      pick_idx          = hit ? cand : pick_idx;
      pick_valid        = pick_valid | hit;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (adv_en) begin
      rr_ptr_d = (adv_idx == IDX_W'(NUM_REQ - 1)) ? '0 : adv_idx + IDX_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/msq_write_arbiter.sv
// Shares one register-write master between several requesters: round-robin
// capture, issue, start-timeout / failure retry, and per-requester done/error.
module msq_write_arbiter
  import msq_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int MAX_RETRIES   = 2,
  parameter int START_TIMEOUT = 15
) (
  input logic                S_AXI_ACLK,
  input logic                S_AXI_ARESET,
  msq_write_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 8;

  if (!req_count_ok(NUM_REQ)) begin : g_bad_num_req
    $error("msq_write_arbiter: NUM_REQ must be within 2..8");
  end

  arb_state_e              state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [NUM_REQ-1:0]      error_q, error_d;
  logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    write_q, write_d;
  logic                    arb_busy_q, arb_busy_d;
  logic [FAIL_CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0]        attempt_q, attempt_d;
  logic [CNT_W-1:0]        timer_q, timer_d;
  logic                    ok_q, ok_d;
  logic                    attempt_fail;
  logic                    adv_en;
  logic                    pick_valid;
  logic [NUM_REQ-1:0]      pick_onehot;
  logic [IDX_W-1:0]        pick_idx;

  msq_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .clk         (S_AXI_ACLK),
    .rst         (S_AXI_ARESET),
    .req         (bus.req_write),
    .adv_en      (adv_en),
    .adv_idx     (grant_idx_q),
    .pick_valid  (pick_valid),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_idx_d  = grant_idx_q;
    done_d       = '0;
    error_d      = '0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    write_d      = 1'b0;
    fail_cnt_d   = fail_cnt_q;
    attempt_d    = attempt_q;
    timer_d      = timer_q;
    ok_d         = ok_q;
    attempt_fail = 1'b0;
    adv_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d     = ST_ISSUE;
          grant_d     = pick_onehot;
          grant_idx_d = pick_idx;
          waddr_d     = bus.req_waddr[slice_lo(int'(pick_idx), ADDR_WIDTH) +: ADDR_WIDTH];
          wdata_d     = bus.req_wdata[slice_lo(int'(pick_idx), DATA_WIDTH) +: DATA_WIDTH];
          wstrb_d     = bus.req_wstrb[slice_lo(int'(pick_idx), STRB_W) +: STRB_W];
          attempt_d   = '0;
          ok_d        = 1'b0;
          write_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        timer_d = CNT_W'(START_TIMEOUT);
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        // Counter reaching zero is the timeout, START_TIMEOUT+1 cycles after issue.
        if (bus.m_axi_write_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q <= CNT_W'(1)) begin
          attempt_fail = 1'b1;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (bus.m_axi_write_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (bus.m_axi_write_failed) begin
          attempt_fail = 1'b1;
        end else begin
          ok_d    = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done_d  = ok_q ? grant_q : '0;
        error_d = ok_q ? '0 : grant_q;
        grant_d = '0;
        adv_en  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (attempt_fail) begin
      fail_cnt_d = (fail_cnt_q == '1) ? fail_cnt_q : fail_cnt_q + 1'b1;
      if (attempt_q < CNT_W'(MAX_RETRIES)) begin
        attempt_d = attempt_q + CNT_W'(1);
        write_d   = 1'b1;
        state_d   = ST_ISSUE;
      end else begin
        ok_d    = 1'b0;
        state_d = ST_FINISH;
      end
    end else begin
      fail_cnt_d = fail_cnt_q;
    end

    arb_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      error_q     <= '0;
      grant_idx_q <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      arb_busy_q  <= 1'b0;
      fail_cnt_q  <= '0;
      attempt_q   <= '0;
      timer_q     <= '0;
      ok_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      error_q     <= error_d;
      grant_idx_q <= grant_idx_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      write_q     <= write_d;
      arb_busy_q  <= arb_busy_d;
      fail_cnt_q  <= fail_cnt_d;
      attempt_q   <= attempt_d;
      timer_q     <= timer_d;
      ok_q        <= ok_d;
    end
  end

  assign bus.req_grant   = grant_q;
  assign bus.req_done    = done_q;
  assign bus.req_error   = error_q;
  assign bus.m_axi_waddr = waddr_q;
  assign bus.m_axi_wdata = wdata_q;
  assign bus.m_axi_wstrb = wstrb_q;
  assign bus.m_axi_write = write_q;
  assign bus.arb_busy    = arb_busy_q;
  assign bus.fail_count  = fail_cnt_q;

endmodule

// File: tb/tb_msq_write_arbiter.sv
// Directed bench for msq_write_arbiter: a cycle table for one clean write,
// then hand-written retry, timeout, round-robin and mid-transaction reset runs.
module tb_msq_write_arbiter;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  msq_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  msq_write_arbiter #(
    .NUM_REQ       (NR),
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .MAX_RETRIES   (2),
    .START_TIMEOUT (15)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .bus          (bus)
  );

  typedef struct {
    logic [2:0] req;
    logic       busy;
    logic       failed;
    logic [2:0] grant;
    logic       write;
    logic [2:0] done;
    logic [2:0] err;
    logic       ab;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_fields(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.req_waddr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
    bus.req_wstrb[i*4 +: 4]   = s;
  endtask

  task automatic reset_dut();
    bus.req_write          = '0;
    bus.m_axi_write_busy   = 1'b0;
    bus.m_axi_write_failed = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_write(output bit found);
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.m_axi_write) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Answers one issue: busy high two cycles, then completion with the given fail flag.
  task automatic serve(input logic fail, output logic [2:0] g);
    bit found;
    wait_write(found);
    chk("strobe_seen", 64'(found), 64'd1);
    g = bus.req_grant;
    bus.m_axi_write_busy = 1'b1;
    tick();
    tick();
    bus.m_axi_write_busy   = 1'b0;
    bus.m_axi_write_failed = fail;
    tick();
    bus.m_axi_write_failed = 1'b0;
  endtask

  task automatic strobe_gap(output int gap);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!bus.m_axi_write && gap < 40);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] g;
    bit         found;
    int         gap;
    int         n;

    vecs[0] = '{3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 3'b000, 3'b000, 1'b1};
    vecs[1] = '{3'b010, 1'b0, 1'b0, 3'b010, 1'b0, 3'b000, 3'b000, 1'b1};
    vecs[2] = '{3'b010, 1'b1, 1'b0, 3'b010, 1'b0, 3'b000, 3'b000, 1'b1};
    vecs[3] = '{3'b010, 1'b1, 1'b0, 3'b010, 1'b0, 3'b000, 3'b000, 1'b1};
    vecs[4] = '{3'b010, 1'b1, 1'b0, 3'b010, 1'b0, 3'b000, 3'b000, 1'b1};
    vecs[5] = '{3'b010, 1'b1, 1'b0, 3'b010, 1'b0, 3'b000, 3'b000, 1'b1};
    vecs[6] = '{3'b010, 1'b0, 1'b0, 3'b010, 1'b0, 3'b000, 3'b000, 1'b1};
    vecs[7] = '{3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 3'b010, 3'b000, 1'b0};
    vecs[8] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0};

    bus.req_write          = '0;
    bus.req_waddr          = '0;
    bus.req_wdata          = '0;
    bus.req_wstrb          = '0;
    bus.m_axi_write_busy   = 1'b0;
    bus.m_axi_write_failed = 1'b0;
    set_fields(0, 32'h1000_0004, 32'h1234_5678, 4'h3);
    set_fields(1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF);
    set_fields(2, 32'h2000_0020, 32'hCAFE_F00D, 4'hC);

    tick();
    tick();
    chk("rst_grant", 64'(bus.req_grant), 64'd0);
    chk("rst_done", 64'(bus.req_done), 64'd0);
    chk("rst_error", 64'(bus.req_error), 64'd0);
    chk("rst_write", 64'(bus.m_axi_write), 64'd0);
    chk("rst_waddr", 64'(bus.m_axi_waddr), 64'd0);
    chk("rst_wdata", 64'(bus.m_axi_wdata), 64'd0);
    chk("rst_arb_busy", 64'(bus.arb_busy), 64'd0);
    chk("rst_fail_count", 64'(bus.fail_count), 64'd0);
    rst = 1'b0;

    // Single clean write from requester 1, one table row per cycle.
    for (int k = 0; k < 9; k++) begin
      bus.req_write          = vecs[k].req;
      bus.m_axi_write_busy   = vecs[k].busy;
      bus.m_axi_write_failed = vecs[k].failed;
      tick();
      chk($sformatf("tbl%0d_grant", k), 64'(bus.req_grant), 64'(vecs[k].grant));
      chk($sformatf("tbl%0d_write", k), 64'(bus.m_axi_write), 64'(vecs[k].write));
      chk($sformatf("tbl%0d_done", k), 64'(bus.req_done), 64'(vecs[k].done));
      chk($sformatf("tbl%0d_error", k), 64'(bus.req_error), 64'(vecs[k].err));
      chk($sformatf("tbl%0d_arb_busy", k), 64'(bus.arb_busy), 64'(vecs[k].ab));
      if (k == 0) begin
        chk("single_waddr", 64'(bus.m_axi_waddr), 64'h4000_0010);
        chk("single_wdata", 64'(bus.m_axi_wdata), 64'hDEAD_BEEF);
        chk("single_wstrb", 64'(bus.m_axi_wstrb), 64'hF);
      end
    end
    chk("single_fail_count", 64'(bus.fail_count), 64'd0);

    // Round-robin with all requesters held.
    reset_dut();
    bus.req_write = 3'b111;
    for (int t = 0; t < 6; t++) begin
      serve(1'b0, g);
      chk($sformatf("rr%0d_grant", t), 64'(g), 64'(3'b001 << (t % 3)));
      tick();
      chk($sformatf("rr%0d_done", t), 64'(bus.req_done), 64'(3'b001 << (t % 3)));
    end
    bus.req_write = 3'b000;
    tick();
    chk("rr_fail_count", 64'(bus.fail_count), 64'd0);

    // One failed attempt, then success on the retry.
    reset_dut();
    bus.req_write = 3'b001;
    serve(1'b1, g);
    chk("retry_grant", 64'(g), 64'b001);
    chk("retry_reissue", 64'(bus.m_axi_write), 64'd1);
    chk("retry_waddr", 64'(bus.m_axi_waddr), 64'h1000_0004);
    chk("retry_wdata", 64'(bus.m_axi_wdata), 64'h1234_5678);
    chk("retry_wstrb", 64'(bus.m_axi_wstrb), 64'h3);
    chk("retry_fail_count", 64'(bus.fail_count), 64'd1);
    serve(1'b0, g);
    tick();
    chk("retry_done", 64'(bus.req_done), 64'b001);
    chk("retry_no_error", 64'(bus.req_error), 64'd0);
    bus.req_write = 3'b000;
    tick();

    // Three failed attempts exhaust the retries.
    reset_dut();
    bus.req_write = 3'b100;
    for (int a = 0; a < 3; a++) begin
      serve(1'b1, g);
      chk($sformatf("exh%0d_grant", a), 64'(g), 64'b100);
      chk($sformatf("exh%0d_write", a), 64'(bus.m_axi_write), (a < 2) ? 64'd1 : 64'd0);
    end
    tick();
    chk("exh_error", 64'(bus.req_error), 64'b100);
    chk("exh_no_done", 64'(bus.req_done), 64'd0);
    chk("exh_fail_count", 64'(bus.fail_count), 64'd3);
    bus.req_write = 3'b000;
    tick();
    chk("exh_error_single", 64'(bus.req_error), 64'd0);

    // Busy never rises: each attempt times out 16 cycles after its strobe.
    reset_dut();
    bus.req_write = 3'b010;
    wait_write(found);
    chk("to_first_strobe", 64'(found), 64'd1);
    for (int s = 0; s < 2; s++) begin
      strobe_gap(gap);
      chk($sformatf("to_gap%0d", s), 64'(gap), 64'd16);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.req_error == 3'b000 && n < 40);
    chk("to_error_latency", 64'(n), 64'd17);
    chk("to_error", 64'(bus.req_error), 64'b010);
    chk("to_fail_count", 64'(bus.fail_count), 64'd3);
    bus.req_write = 3'b000;
    tick();

    // Reset during WAIT_DONE after the pointer has moved to requester 1.
    reset_dut();
    bus.req_write = 3'b001;
    serve(1'b0, g);
    tick();
    chk("mr_done0", 64'(bus.req_done), 64'b001);
    bus.req_write = 3'b011;
    wait_write(found);
    chk("mr_grant1", 64'(bus.req_grant), 64'b010);
    bus.m_axi_write_busy = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mr_grant", 64'(bus.req_grant), 64'd0);
    chk("mr_write", 64'(bus.m_axi_write), 64'd0);
    chk("mr_arb_busy", 64'(bus.arb_busy), 64'd0);
    chk("mr_waddr", 64'(bus.m_axi_waddr), 64'd0);
    chk("mr_fail_count", 64'(bus.fail_count), 64'd0);
    bus.m_axi_write_busy = 1'b0;
    tick();
    rst = 1'b0;
    chk("mr_no_done", 64'(bus.req_done), 64'd0);
    chk("mr_no_error", 64'(bus.req_error), 64'd0);
    tick();
    chk("mr_regrant", 64'(bus.req_grant), 64'b001);
    chk("mr_regrant_write", 64'(bus.m_axi_write), 64'd1);
    chk("mr_regrant_no_done", 64'(bus.req_done), 64'd0);
    bus.req_write = 3'b000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msq_write_arbiter.md
# msq_write_arbiter

Round-robin arbiter and transaction sequencer that shares the micro-sequencer's single register-write master (wdata/waddr/wstrb/write/write_busy/write_failed) between several requesters: the micro-sequencer core, the gradient-update engine and the host-side config path. It captures one request at a time, issues it to the write master, waits for completion, retries on failure or start timeout, and reports done or error per requester. It sits between the requesters and the AXI write-master adapter.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 32, write address width
- MAX_RETRIES, 2, re-issues after the first failed attempt before reporting error
- START_TIMEOUT, 15, cycles after issue to wait for m_axi_write_busy to rise (1..255)

- S_AXI_ACLK  in  1  clock
- S_AXI_ARESET  in  1  asynchronous, active-high reset
- req_write  in  NUM_REQ  per-requester request level; held with stable fields until that requester's done or error pulse
- req_waddr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
- req_wstrb  in  NUM_REQ*4  flattened byte strobes
- req_grant  out  NUM_REQ  one-hot owner of the current transaction, 0 when idle
- req_done  out  NUM_REQ  one-cycle pulse: write completed successfully
- req_error  out  NUM_REQ  one-cycle pulse: retries exhausted
- m_axi_waddr  out  ADDR_WIDTH  registered address to the write master
- m_axi_wdata  out  DATA_WIDTH  registered data
- m_axi_wstrb  out  4  registered strobes
- m_axi_write  out  1  one-cycle issue strobe
- m_axi_write_busy  in  1  write master busy
- m_axi_write_failed  in  1  failure flag, valid in the cycle busy is first sampled low after being high
- arb_busy  out  1  high in any state other than IDLE
- fail_count  out  16  saturating count of failed attempts, including timeouts

## Operation
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, FINISH.
- IDLE: if any req_write is high, pick the first asserted index starting at rr_ptr (wrapping). Capture its waddr/wdata/wstrb into the m_axi_* registers, set req_grant, clear attempt counter, go to ISSUE.
- ISSUE: m_axi_write=1 for exactly this cycle. Load the timeout counter with START_TIMEOUT. Go to WAIT_START.
- WAIT_START: if busy=1, go to WAIT_DONE. Otherwise decrement the counter; at 0 the attempt failed (timeout) and goes to retry evaluation.
- WAIT_DONE: when busy=0, sample m_axi_write_failed. If 0, go to FINISH with success. If 1, the attempt failed and goes to retry evaluation.
- Retry evaluation: increment fail_count (saturating at 16'hFFFF). If attempt < MAX_RETRIES, increment attempt and go to ISSUE with the same captured fields. Otherwise go to FINISH with error.
- FINISH: pulse req_done[g] or req_error[g]. Clear req_grant. Set rr_ptr to (g+1) mod NUM_REQ. Go to IDLE.
- Dropping req_write while granted has no effect; the transaction runs to completion and still pulses done/error.
- Requester inputs are captured at grant and are not re-read during retries.

## Timing
- Reset: state IDLE, rr_ptr=0, every output 0 (req_grant, req_done, req_error, m_axi_*, arb_busy, fail_count). Outputs clear asynchronously.
- Reset mid-transaction abandons the write: no done or error pulse, m_axi_write goes low immediately.
- req_write rising in IDLE at cycle N produces req_grant at N+1, m_axi_write and valid m_axi_* at N+1, and arb_busy at N+1.
- m_axi_* fields are stable from issue until FINISH.
- done/error pulse occurs 2 cycles after the edge where busy is sampled low (WAIT_DONE→FINISH, then FINISH registers the pulse).
- Minimum spacing between issues of different transactions is 3 cycles: FINISH, IDLE, ISSUE.
- A retry issues the cycle after failure detection.
- Timeout fires exactly START_TIMEOUT+1 cycles after the issue strobe if busy never rises.
- Busy already high in the ISSUE cycle is ignored; only WAIT_START samples it.
- Fairness: with all requesters continuously asserted, grants rotate 0,1,2,0,...

## Structure
- Shared package msq_pkg: state enum, NUM_REQ bound checks, fail_count width constant, flattened-slice index helpers.
- One sub-module: msq_rr_picker. Combinational plus registered rr_ptr; inputs are the request vector and pointer, output is the one-hot pick and its index.

## Test plan
- Single request: req 1, addr 0x4000_0010, data 0xDEADBEEF, busy high 4 cycles, failed=0 -> one m_axi_write pulse with those fields, req_done[1] pulse, fail_count=0.
- Round-robin: all three requesters held for 6 transactions -> grant order 0,1,2,0,1,2, each done once per round.
- Retry success: first attempt failed=1, second failed=0 -> two issue strobes with identical fields, req_done pulse, fail_count=1.
- Retry exhaustion with MAX_RETRIES=2: three failed attempts -> three strobes, req_error pulse, no done, fail_count=3.
- Start timeout with START_TIMEOUT=15: busy never rises -> re-issue 16 cycles after each strobe, error after 3 strobes.
- Reset asserted during WAIT_DONE -> all outputs 0 immediately, no pulse; after release, a held request is re-granted from rr_ptr=0.
